// File: rtl/alt_disable_sequencer.sv
// alt_disable_sequencer: walks an alt's channel-address list in memory and
// runs the Disable unit on each channel. It records the first delivered
// message and hands any sender that must be woken to the scheduler.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start/listAddr/count/rxPid   request and its operands (latched at start)
//   busy/done             sequence in progress / one-cycle completion pulse
//   hasMessage/message/selIndex  first delivery and its list index
//   schedValid/schedPid/schedReady  valid/ready handshake to the scheduler
//   dis*                  Disable unit control, results and memory request
//   address/readWriteMode/dataIn/dataOut  shared memory port (1 = write)
module alt_disable_sequencer #(
    parameter int addrBits  = 16,
    parameter int dataBits  = 16,
    parameter int countBits = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addrBits-1:0]  listAddr,
    input  logic [countBits-1:0] count,
    input  logic [addrBits-1:0]  rxPid,
    output logic                 busy,
    output logic                 done,
    output logic                 hasMessage,
    output logic [dataBits-1:0]  message,
    output logic [countBits-1:0] selIndex,
    output logic                 schedValid,
    output logic [addrBits-1:0]  schedPid,
    input  logic                 schedReady,
    output logic                 disEnabled,
    output logic [addrBits-1:0]  disChannel,
    output logic [addrBits-1:0]  disRxPid,
    output logic                 disRxHadMessageInAlt,
    input  logic                 disFinished,
    input  logic                 disShouldScheduleSender,
    input  logic [addrBits-1:0]  disScheduleTxPid,
    input  logic                 disHasDeliveredMessage,
    input  logic [dataBits-1:0]  disDeliveredMessage,
    input  logic                 disRxHasMessageInAlt,
    input  logic [addrBits-1:0]  disAddress,
    input  logic                 disReadWriteMode,
    input  logic [dataBits-1:0]  disDataIn,
    output logic [addrBits-1:0]  address,
    output logic                 readWriteMode,
    output logic [dataBits-1:0]  dataIn,
    input  logic [dataBits-1:0]  dataOut
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] LATCH   = 3'd2;
    localparam logic [2:0] DISABLE = 3'd3;
    localparam logic [2:0] RESULT  = 3'd4;
    localparam logic [2:0] SCHED   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [addrBits-1:0]  list_addr_q, list_addr_d;
    logic [countBits-1:0] count_q, count_d;
    logic [addrBits-1:0]  rx_pid_q, rx_pid_d;
    logic [countBits-1:0] index_q, index_d;
    logic                 has_msg_q, has_msg_d;
    logic [dataBits-1:0]  message_q, message_d;
    logic [countBits-1:0] sel_index_q, sel_index_d;
    logic [addrBits-1:0]  sched_pid_q, sched_pid_d;
    logic [addrBits-1:0]  channel_q, channel_d;

    // Extra bit so index+1 never wraps before the compare with count.
    logic [countBits:0]   idx_inc;
    logic                 more;
    logic                 own_mem;

    // The Disable unit's own view of the receiver's state is not needed
    // here; hasMessage is tracked locally from the delivery results.
    logic unused_rx_has;
    assign unused_rx_has = disRxHasMessageInAlt;

    assign idx_inc = {1'b0, index_q} + 1'b1;
    assign more    = idx_inc < {1'b0, count_q};

    always_comb begin
        state_d     = state_q;
        list_addr_d = list_addr_q;
        count_d     = count_q;
        rx_pid_d    = rx_pid_q;
        index_d     = index_q;
        has_msg_d   = has_msg_q;
        message_d   = message_q;
        sel_index_d = sel_index_q;
        sched_pid_d = sched_pid_q;
        channel_d   = channel_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    list_addr_d = listAddr;
                    count_d     = count;
                    rx_pid_d    = rxPid;
                    index_d     = '0;
                    has_msg_d   = 1'b0;
                    message_d   = '0;
                    sel_index_d = '0;
                    state_d     = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                channel_d = addrBits'(dataOut);
                state_d   = DISABLE;
            end
            DISABLE: begin
                if (disFinished) state_d = RESULT;
            end
            RESULT: begin
                // A second delivery is a protocol error; keep the first.
                if (disHasDeliveredMessage && !has_msg_q) begin
                    has_msg_d   = 1'b1;
                    message_d   = disDeliveredMessage;
                    sel_index_d = index_q;
                end
                if (disShouldScheduleSender) begin
                    sched_pid_d = disScheduleTxPid;
                    state_d     = SCHED;
                end else begin
                    index_d = idx_inc[countBits-1:0];
                    state_d = more ? FETCH : DONE;
                end
            end
            SCHED: begin
                if (schedReady) begin
                    index_d = idx_inc[countBits-1:0];
                    state_d = more ? FETCH : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            list_addr_q <= '0;
            count_q     <= '0;
            rx_pid_q    <= '0;
            index_q     <= '0;
            has_msg_q   <= 1'b0;
            message_q   <= '0;
            sel_index_q <= '0;
            sched_pid_q <= '0;
            channel_q   <= '0;
        end else begin
            state_q     <= state_d;
            list_addr_q <= list_addr_d;
            count_q     <= count_d;
            rx_pid_q    <= rx_pid_d;
            index_q     <= index_d;
            has_msg_q   <= has_msg_d;
            message_q   <= message_d;
            sel_index_q <= sel_index_d;
            sched_pid_q <= sched_pid_d;
            channel_q   <= channel_d;
        end
    end

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign schedValid = (state_q == SCHED);
    assign schedPid   = sched_pid_q;
    assign hasMessage = has_msg_q;
    assign message    = message_q;
    assign selIndex   = sel_index_q;

    assign disEnabled           = (state_q == DISABLE);
    assign disChannel           = channel_q;
    assign disRxPid             = rx_pid_q;
    assign disRxHadMessageInAlt = disEnabled & has_msg_q;

    // The list read owns memory in FETCH/LATCH; the Disable unit has it
    // otherwise. Reset hands it to the Disable side with writes blocked.
    assign own_mem = !reset && ((state_q == FETCH) || (state_q == LATCH));

    always_comb begin
        address       = disAddress;
        readWriteMode = disReadWriteMode & ~reset;
        dataIn        = disDataIn;
        if (own_mem) begin
            address       = list_addr_q + addrBits'(index_q);
            readWriteMode = 1'b0;
            dataIn        = '0;
        end
    end

endmodule

// File: tb/tb_alt_disable_sequencer.sv
// tb_alt_disable_sequencer: directed bench with a memory model, a small
// Disable-unit model and hand-computed expected values.
module tb_alt_disable_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] listAddr = '0;
    logic [3:0]  count = '0;
    logic [15:0] rxPid = '0;
    logic        busy, done, hasMessage;
    logic [15:0] message;
    logic [3:0]  selIndex;
    logic        schedValid;
    logic [15:0] schedPid;
    logic        schedReady;
    logic        disEnabled;
    logic [15:0] disChannel, disRxPid;
    logic        disRxHadMessageInAlt;
    logic        disReadWriteMode;
    logic [15:0] disAddress;
    logic [15:0] address;
    logic        readWriteMode;
    logic [15:0] dataIn, dataOut;

    logic        dis_fin = 0, dis_sched = 0, dis_deliv = 0, dis_rxhas = 0;
    logic [15:0] dis_txpid = '0, dis_msg = '0, dis_addr = '0, dis_din = '0;
    logic        dis_rw = 0, rw_force = 0;
    int          dis_lat = 0;
    logic        force_deliver = 0;
    int          dcnt = 0;

    logic        auto_ack = 1, ack_q = 0, man_ready = 0;
    assign schedReady       = auto_ack ? ack_q : man_ready;
    assign disReadWriteMode = dis_rw | rw_force;
    assign disAddress       = rw_force ? 16'd5 : dis_addr;

    logic [15:0] ram [0:63];
    logic        poke_en = 0;
    logic [5:0]  poke_a = '0;
    logic [15:0] poke_d = '0;

    int checks = 0;
    int errors = 0;

    int          passes = 0, sched_cnt = 0, rx_bad = 0;
    logic [15:0] chan_log [0:63];
    logic        had_log [0:63];
    logic [15:0] last_pid = '0;
    logic [15:0] exp_rx = '0;
    logic        prev_en = 0, prev_sv = 0;

    always #5 clk = ~clk;

    alt_disable_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .listAddr(listAddr), .count(count), .rxPid(rxPid),
        .busy(busy), .done(done), .hasMessage(hasMessage),
        .message(message), .selIndex(selIndex),
        .schedValid(schedValid), .schedPid(schedPid),
        .schedReady(schedReady),
        .disEnabled(disEnabled), .disChannel(disChannel),
        .disRxPid(disRxPid),
        .disRxHadMessageInAlt(disRxHadMessageInAlt),
        .disFinished(dis_fin),
        .disShouldScheduleSender(dis_sched),
        .disScheduleTxPid(dis_txpid),
        .disHasDeliveredMessage(dis_deliv),
        .disDeliveredMessage(dis_msg),
        .disRxHasMessageInAlt(dis_rxhas),
        .disAddress(disAddress),
        .disReadWriteMode(disReadWriteMode),
        .disDataIn(dis_din),
        .address(address), .readWriteMode(readWriteMode),
        .dataIn(dataIn), .dataOut(dataOut)
    );

    always @(posedge clk) begin
        if (poke_en) ram[poke_a] <= poke_d;
        else if (readWriteMode) ram[address[5:0]] <= dataIn;
        dataOut <= ram[address[5:0]];
    end

    // Disable model: empty or own-PID channel is cleared; a ready sender
    // delivers its message (ram[ch+1]) unless the receiver already has one.
    always @(negedge clk) begin
        logic [5:0]  ch;
        logic [15:0] v;
        ack_q = schedValid;
        if (disEnabled) begin
            if (dcnt == 0) begin
                dis_sched = 0; dis_deliv = 0; dis_rxhas = 0;
                dis_msg = '0; dis_txpid = '0;
            end
            if (dcnt == dis_lat) begin
                ch = disChannel[5:0];
                v = ram[ch];
                dis_fin = 1;
                if (v == 0 || v == disRxPid) begin
                    dis_addr = disChannel; dis_rw = 1; dis_din = '0;
                end else if (!disRxHadMessageInAlt) begin
                    dis_deliv = 1; dis_msg = ram[ch + 6'd1];
                    dis_sched = 1; dis_txpid = v; dis_rxhas = 1;
                    dis_addr = disChannel; dis_rw = 1; dis_din = '0;
                end else if (force_deliver) begin
                    dis_deliv = 1; dis_msg = ram[ch + 6'd1];
                end
            end
            dcnt++;
        end else begin
            dis_fin = 0; dis_rw = 0; dcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (disEnabled && !prev_en) begin
            chan_log[passes[5:0]] = disChannel;
            had_log[passes[5:0]] = disRxHadMessageInAlt;
            passes++;
        end
        if (disEnabled && disRxPid != exp_rx) rx_bad++;
        if (schedValid && !prev_sv) begin
            sched_cnt++;
            last_pid = schedPid;
        end
        prev_en = disEnabled;
        prev_sv = schedValid;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [15:0] d);
        poke_a = a; poke_d = d; poke_en = 1;
        @(negedge clk);
        poke_en = 0;
    endtask

    task automatic start_seq(input logic [15:0] a, input logic [3:0] c,
                             input logic [15:0] r);
        listAddr = a; count = c; rxPid = r; exp_rx = r;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic wait_sv(output int cyc);
        cyc = 1;
        while (!schedValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!schedValid) check("sv_timeout", 0, 1);
    endtask

    initial begin
        int cyc, p0, s0, r0;
        logic stable;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_has", 32'(hasMessage), 0);
        check("rst_sv", 32'(schedValid), 0);
        check("rst_dis_en", 32'(disEnabled), 0);
        rw_force = 1;
        #1;
        check("rst_rw_blocked", 32'(readWriteMode), 0);
        check("rst_addr_mux", 32'(address), 5);
        rw_force = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        // Empty list
        p0 = passes; s0 = sched_cnt;
        start_seq(16'd20, 4'd0, 16'd7);
        wait_done(1, cyc);
        check("empty_lat", 32'(cyc), 1);
        check("empty_has", 32'(hasMessage), 0);
        check("empty_busy", 32'(busy), 0);
        check("empty_passes", 32'(passes - p0), 0);
        check("empty_sched", 32'(sched_cnt - s0), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);

        // No senders
        poke(20, 2); poke(21, 4); poke(2, 7); poke(4, 7);
        p0 = passes; s0 = sched_cnt; r0 = rx_bad;
        start_seq(16'd20, 4'd2, 16'd7);
        wait_done(1, cyc);
        check("nos_lat", 32'(cyc), 9);
        check("nos_passes", 32'(passes - p0), 2);
        check("nos_ch0", 32'(chan_log[p0[5:0]]), 2);
        check("nos_ch1", 32'(chan_log[p0[5:0] + 6'd1]), 4);
        check("nos_had0", 32'(had_log[p0[5:0]]), 0);
        check("nos_had1", 32'(had_log[p0[5:0] + 6'd1]), 0);
        check("nos_has", 32'(hasMessage), 0);
        check("nos_ram2", 32'(ram[2]), 0);
        check("nos_ram4", 32'(ram[4]), 0);
        check("nos_sched", 32'(sched_cnt - s0), 0);
        check("nos_rxpid", 32'(rx_bad - r0), 0);

        // Sender on second channel, with backpressure
        poke(24, 2); poke(25, 8); poke(2, 7); poke(8, 8); poke(9, 42);
        auto_ack = 0; man_ready = 0; s0 = sched_cnt;
        start_seq(16'd24, 4'd2, 16'd7);
        wait_sv(cyc);
        check("snd_sv_lat", 32'(cyc), 9);
        check("snd_has_early", 32'(hasMessage), 1);
        stable = 1;
        repeat (5) begin
            @(negedge clk);
            if (!schedValid || schedPid != 16'd8) stable = 0;
        end
        check("bp_stable", 32'(stable), 1);
        man_ready = 1;
        @(negedge clk);
        man_ready = 0;
        check("snd_sv_drop", 32'(schedValid), 0);
        wait_done(1, cyc);
        check("snd_msg", 32'(message), 42);
        check("snd_sel", 32'(selIndex), 1);
        check("snd_has", 32'(hasMessage), 1);
        check("snd_sched", 32'(sched_cnt - s0), 1);
        check("snd_pid", 32'(last_pid), 8);
        check("snd_ram8", 32'(ram[8]), 0);
        auto_ack = 1;

        // Two ready senders
        poke(28, 8); poke(29, 10); poke(8, 8); poke(9, 42);
        poke(10, 13); poke(11, 99);
        p0 = passes; s0 = sched_cnt;
        start_seq(16'd28, 4'd2, 16'd7);
        wait_done(1, cyc);
        check("two_lat", 32'(cyc), 10);
        check("two_msg", 32'(message), 42);
        check("two_sel", 32'(selIndex), 0);
        check("two_sched", 32'(sched_cnt - s0), 1);
        check("two_pid", 32'(last_pid), 8);
        check("two_had0", 32'(had_log[p0[5:0]]), 0);
        check("two_had1", 32'(had_log[p0[5:0] + 6'd1]), 1);
        check("two_ram10", 32'(ram[10]), 13);

        // Slow Disable, and a second (erroneous) delivery is ignored
        poke(8, 8);
        dis_lat = 2; force_deliver = 1;
        start_seq(16'd28, 4'd2, 16'd7);
        wait_done(1, cyc);
        check("dup_lat", 32'(cyc), 14);
        check("dup_msg", 32'(message), 42);
        check("dup_sel", 32'(selIndex), 0);
        check("dup_has", 32'(hasMessage), 1);
        dis_lat = 0; force_deliver = 0;

        // Reset while in SCHED
        poke(8, 8);
        auto_ack = 0; man_ready = 0;
        start_seq(16'd24, 4'd2, 16'd7);
        wait_sv(cyc);
        reset = 1;
        @(negedge clk);
        check("rs_busy", 32'(busy), 0);
        check("rs_done", 32'(done), 0);
        check("rs_sv", 32'(schedValid), 0);
        check("rs_pid", 32'(schedPid), 0);
        check("rs_has", 32'(hasMessage), 0);
        check("rs_msg", 32'(message), 0);
        check("rs_sel", 32'(selIndex), 0);
        check("rs_dis_en", 32'(disEnabled), 0);
        check("rs_chan", 32'(disChannel), 0);
        check("rs_rxpid", 32'(disRxPid), 0);
        check("rs_had", 32'(disRxHadMessageInAlt), 0);
        reset = 0;
        auto_ack = 1;
        poke(2, 7); poke(4, 7);
        s0 = sched_cnt;
        start_seq(16'd20, 4'd2, 16'd7);
        wait_done(1, cyc);
        check("post_rs_lat", 32'(cyc), 9);
        check("post_rs_has", 32'(hasMessage), 0);
        check("post_rs_sched", 32'(sched_cnt - s0), 0);

        // start while busy is ignored
        poke(2, 7); poke(4, 7);
        p0 = passes; r0 = rx_bad;
        start_seq(16'd20, 4'd2, 16'd7);
        @(negedge clk);
        listAddr = 16'd28; count = 4'd0; rxPid = 16'd9;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(3, cyc);
        check("busy_lat", 32'(cyc), 9);
        check("busy_passes", 32'(passes - p0), 2);
        check("busy_ch0", 32'(chan_log[p0[5:0]]), 2);
        check("busy_ch1", 32'(chan_log[p0[5:0] + 6'd1]), 4);
        check("busy_rxpid", 32'(rx_bad - r0), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
